// File: rtl/serial_line_pkg.sv
// Shared constants, frame layout offsets and state encoding for the serial line link.
package serial_line_pkg;

    localparam int unsigned N_FRAME        = 979;
    localparam int unsigned HS_W           = 16;
    localparam int unsigned NUM_W          = 35;
    localparam int unsigned N_NUM          = 27;
    localparam int unsigned N_PAD          = 2;
    localparam int unsigned ADDR_W         = 5;
    localparam int unsigned CNT_W          = 10;
    localparam int unsigned BIT_CYCLES_DEF = 1000;
    localparam int unsigned GAP_CYCLES_DEF = 1000;

    // Frame bit offsets (MSB of each field), bit N_FRAME-1 goes out first
    localparam int unsigned HS_INIT_MSB  = N_FRAME - 1;
    localparam int unsigned NUM0_MSB     = HS_INIT_MSB - HS_W;
    localparam int unsigned HS_FINAL_MSB = NUM0_MSB - N_NUM * NUM_W;
    localparam int unsigned PAD_MSB      = N_PAD - 1;

    // Register-file addresses of the handshake words
    localparam int unsigned ADDR_HS_INIT  = 27;
    localparam int unsigned ADDR_HS_FINAL = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // MSB position of number i inside the frame
    function automatic int unsigned num_msb(input int unsigned i);
        return NUM0_MSB - i * NUM_W;
    endfunction

endpackage

// File: rtl/serial_line_tx_if.sv
// Write port, frame request and line/status outputs of the serial line transmitter.
interface serial_line_tx_if;
    import serial_line_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [NUM_W-1:0]  wr_data;
    logic              start;
    logic              line_out;
    logic              trig_out;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  line_out, trig_out, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output line_out, trig_out, busy, done
    );

endinterface

// File: rtl/serial_bit_timer.sv
// Slot counter with clear/enable; slot_end_c strobes on the last clock of each slot.
module serial_bit_timer #(
    parameter int unsigned CYCLES = 1000,
    parameter int unsigned CNT_W  = 10
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic slot_end_c
);

    logic [CNT_W-1:0] cnt_q;

    assign slot_end_c = en_i && (cnt_q == CNT_W'(CYCLES - 1));

    // Count enabled clocks, wrapping at the end of each slot
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || slot_end_c) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_line_tx.sv
// Serial line transmitter: snapshots a 979-bit frame and shifts it out MSB-first.
// Optional even parity in pad bit 1 when SERIAL_LINE_TX_PARITY_EN is defined.
module serial_line_tx
    import serial_line_pkg::*;
#(
    parameter int unsigned   BIT_CYCLES = BIT_CYCLES_DEF,
    parameter int unsigned   GAP_CYCLES = GAP_CYCLES_DEF,
    parameter logic [HS_W-1:0] HS_INIT  = 16'hA5C3,
    parameter logic [HS_W-1:0] HS_FINAL = 16'h3C5A
) (
    input  logic              clk_in,
    input  logic              rst_n,
    serial_line_tx_if.slave   bus
);

    logic [NUM_W-1:0]   nums_q [N_NUM];
    logic [HS_W-1:0]    hs_init_q;
    logic [HS_W-1:0]    hs_final_q;
    logic [N_FRAME-1:0] frame_c;
    logic [N_FRAME-1:0] sh_q;
    logic [CNT_W-1:0]   idx_q;
    tx_state_e          state_q;
    logic               line_q;
    logic               trig_q;
    logic               busy_q;
    logic               done_q;
    logic               slot_end_c;
    logic               gap_end_c;

    // Register file; a write lands the cycle after the strobe
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NUM; i++) nums_q[i] <= '0;
            hs_init_q  <= HS_INIT;
            hs_final_q <= HS_FINAL;
        end else if (bus.wr_en) begin
            for (int i = 0; i < N_NUM; i++) begin
                if (bus.wr_addr == ADDR_W'(i)) nums_q[i] <= bus.wr_data;
            end
            if (bus.wr_addr == ADDR_W'(ADDR_HS_INIT))  hs_init_q  <= bus.wr_data[HS_W-1:0];
            if (bus.wr_addr == ADDR_W'(ADDR_HS_FINAL)) hs_final_q <= bus.wr_data[HS_W-1:0];
        end
    end

    // Frame image assembled from the current register contents
    always_comb begin
        frame_c = '0;
        frame_c[HS_INIT_MSB -: HS_W] = hs_init_q;
        for (int i = 0; i < N_NUM; i++) begin
            frame_c[num_msb(i) -: NUM_W] = nums_q[i];
        end
        frame_c[HS_FINAL_MSB -: HS_W] = hs_final_q;
`ifdef SERIAL_LINE_TX_PARITY_EN
        frame_c[PAD_MSB] = ^frame_c[N_FRAME-1:N_PAD];
`endif
    end

    serial_bit_timer #(.CYCLES(BIT_CYCLES), .CNT_W(CNT_W)) u_slot_timer (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .clr_i      (state_q != ST_SEND),
        .en_i       (state_q == ST_SEND),
        .slot_end_c (slot_end_c)
    );

    serial_bit_timer #(.CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) u_gap_timer (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .clr_i      (state_q != ST_GAP),
        .en_i       (state_q == ST_GAP),
        .slot_end_c (gap_end_c)
    );

    // Frame sequencer: IDLE -> TRIG -> SEND (979 slots) -> GAP -> IDLE
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            line_q  <= 1'b0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    line_q <= 1'b0;
                    if (bus.start) begin
                        sh_q    <= frame_c;
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    line_q  <= sh_q[N_FRAME-1];
                    idx_q   <= CNT_W'(N_FRAME - 1);
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (slot_end_c) begin
                        if (idx_q == '0) begin
                            line_q  <= 1'b0;
                            state_q <= ST_GAP;
                        end else begin
                            idx_q  <= idx_q - 1'b1;
                            sh_q   <= {sh_q[N_FRAME-2:0], 1'b0};
                            line_q <= sh_q[N_FRAME-2];
                        end
                    end
                end
                ST_GAP: begin
                    line_q <= 1'b0;
                    if (gap_end_c) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.line_out = line_q;
    assign bus.trig_out = trig_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
